// File: rtl/fm_bram_1_arb.sv
// Two-channel burst arbiter in front of a single-port feature-map BRAM (port A).
// Define FM_BRAM_1_ARB_RR_EN for round-robin tie breaking; otherwise channel 0 has fixed priority.
module fm_bram_1_arb #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [ADDR_W-1:0] req0_len,
  input  logic [DATA_W-1:0] req0_din,
  input  logic              req1,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [ADDR_W-1:0] req1_len,
  input  logic [DATA_W-1:0] req1_din,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              rd_vld,
  output logic              rd_ch
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              ch_q, ch_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_ch_q, rd_ch_d;
  logic              win;
  logic              in_burst;

  always_comb begin
`ifdef FM_BRAM_1_ARB_RR_EN
    if (req0 && req1) win = ~last_q;
    else              win = req1;
`else
    win = ~req0;
`endif
  end

  assign in_burst = (state_q == S_BURST);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    we_d    = we_q;
    start_d = start_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          ch_d    = win;
          last_d  = win;
          we_d    = win ? req1_we   : req0_we;
          start_d = win ? req1_addr : req0_addr;
          len_d   = win ? req1_len  : req0_len;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rd_vld_d = in_burst & ~we_q;
    rd_ch_d  = ch_q;
  end

  // Pointer resets to "channel 1 granted last" so channel 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ch_q     <= 1'b0;
      we_q     <= 1'b0;
      start_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      we_q     <= we_d;
      start_q  <= start_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rd_vld_q <= rd_vld_d;
      rd_ch_q  <= rd_ch_d;
    end
  end

  assign gnt0       = in_burst & ~ch_q;
  assign gnt1       = in_burst &  ch_q;
  assign done0      = (state_q == S_DONE) & ~ch_q;
  assign done1      = (state_q == S_DONE) &  ch_q;
  assign bram_ena   = in_burst;
  assign bram_wea   = in_burst & we_q;
  assign bram_addra = in_burst ? (start_q + cnt_q) : '0;
  assign bram_dina  = in_burst ? (ch_q ? req1_din : req0_din) : '0;
  assign rd_vld     = rd_vld_q;
  assign rd_ch      = rd_ch_q;

endmodule

// File: tb/tb_fm_bram_1_arb.sv
// Self-checking bench for fm_bram_1_arb; honours FM_BRAM_1_ARB_RR_EN for the tie scenario.
module tb_fm_bram_1_arb;
  localparam int AW = 7;
  localparam int DW = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req0_we, req1, req1_we;
  logic [AW-1:0] req0_addr, req0_len, req1_addr, req1_len;
  logic [DW-1:0] req0_din, req1_din;
  logic          gnt0, gnt1, done0, done1, bram_ena, bram_wea, rd_vld, rd_ch;
  logic [AW-1:0] bram_addra;
  logic [DW-1:0] bram_dina;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fm_bram_1_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req0_we(req0_we), .req0_addr(req0_addr), .req0_len(req0_len), .req0_din(req0_din),
    .req1(req1), .req1_we(req1_we), .req1_addr(req1_addr), .req1_len(req1_len), .req1_din(req1_din),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .rd_vld(rd_vld), .rd_ch(rd_ch)
  );

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic set_req(input bit c, input bit r, input bit we, input logic [AW-1:0] a, input logic [AW-1:0] l);
    if (c) begin req1 = r; req1_we = we; req1_addr = a; req1_len = l; end
    else   begin req0 = r; req0_we = we; req0_addr = a; req0_len = l; end
  endtask

  // Drives one burst on channel c and checks each beat against the burst's own parameters.
  // hold=1 keeps the request asserted (used for back-to-back ties); otherwise it is dropped
  // and the address/length/direction are scrambled after the first beat.
  task automatic run_burst(input bit c, input bit we, input logic [AW-1:0] a,
                           input logic [AW-1:0] len, input bit hold);
    logic [DW-1:0] w;
    logic [AW-1:0] exp_addr;
    bit got;
    bit exp_rv;
    set_req(c, 1'b1, we, a, len);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (c ? gnt1 : gnt0) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL gnt_wait ch=%0d: no grant within 8 cycles", c);
      set_req(c, 1'b0, 1'b0, '0, '0);
      return;
    end
    for (int k = 0; k <= int'(len); k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      exp_addr = AW'((int'(a) + k) % (1 << AW));
      checks++;
      if ({gnt1, gnt0} !== (c ? 2'b10 : 2'b01) || bram_ena !== 1'b1 || bram_wea !== we ||
          bram_addra !== exp_addr || {done1, done0} !== 2'b00) begin
        failures++;
        $display("FAIL beat ch=%0d k=%0d: gnt=%b ena=%b wea=%b addr=%0d done=%b, want gnt=%b ena=1 wea=%b addr=%0d done=00",
                 c, k, {gnt1, gnt0}, bram_ena, bram_wea, bram_addra, {done1, done0},
                 (c ? 2'b10 : 2'b01), we, exp_addr);
      end
      exp_rv = (k > 0) && !we;
      checks++;
      if (rd_vld !== exp_rv || (exp_rv && rd_ch !== c)) begin
        failures++;
        $display("FAIL rd_vld ch=%0d k=%0d: rd_vld=%b rd_ch=%b, want rd_vld=%b rd_ch=%b", c, k, rd_vld, rd_ch, exp_rv, c);
      end
      w = rand_word();
      if (c) req1_din = w; else req0_din = w;
      #1;
      checks++;
      if (bram_dina !== w) begin
        failures++;
        $display("FAIL dina ch=%0d k=%0d: got %h, want %h", c, k, bram_dina[63:0], w[63:0]);
      end
      if (k == 0 && !hold) set_req(c, 1'b0, 1'($urandom), AW'($urandom), AW'($urandom));
    end
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0} !== 2'b00 || bram_ena !== 1'b0 || {done1, done0} !== (c ? 2'b10 : 2'b01) ||
        rd_vld !== !we || (!we && rd_ch !== c)) begin
      failures++;
      $display("FAIL done ch=%0d: gnt=%b ena=%b done=%b rd_vld=%b rd_ch=%b, want gnt=00 ena=0 done=%b rd_vld=%b rd_ch=%b",
               c, {gnt1, gnt0}, bram_ena, {done1, done0}, rd_vld, rd_ch, (c ? 2'b10 : 2'b01), !we, c);
    end
    @(posedge clk); #1;
    checks++;
    if ({gnt1, gnt0, done1, done0, bram_ena, rd_vld} !== 6'b0) begin
      failures++;
      $display("FAIL gap ch=%0d: gnt=%b done=%b ena=%b rd_vld=%b, want all 0", c, {gnt1, gnt0}, {done1, done0}, bram_ena, rd_vld);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req0_we = 0; req0_addr = '0; req0_len = '0; req0_din = '0;
    req1 = 0; req1_we = 0; req1_addr = '0; req1_len = '0; req1_din = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, bram_ena, bram_wea, rd_vld, rd_ch} !== 8'b0 || bram_addra !== '0) begin
      failures++;
      $display("FAIL reset: ctrl=%b addr=%0d, want 0", {gnt0, gnt1, done0, done1, bram_ena, bram_wea, rd_vld, rd_ch}, bram_addra);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    run_burst(1'b0, 1'b1, AW'(10), AW'(3), 1'b0);
  endtask

  task automatic test_read_wrap();
    run_burst(1'b1, 1'b0, AW'(126), AW'(3), 1'b0);
  endtask

  task automatic test_boundaries();
    run_burst(1'b0, 1'b0, AW'(55), AW'(0), 1'b0);
    run_burst(1'b1, 1'b1, AW'(77), AW'(0), 1'b0);
    run_burst(1'b0, 1'b0, AW'(5), AW'(127), 1'b0);
  endtask

  task automatic test_tie();
    bit seq [$];
    bit hold [$];
    rst_n = 1'b0; #1; @(negedge clk); rst_n = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, AW'(40), AW'(1));
    set_req(1'b1, 1'b1, 1'b0, AW'(90), AW'(2));
`ifdef FM_BRAM_1_ARB_RR_EN
    seq  = '{1'b0, 1'b1, 1'b0, 1'b1};
    hold = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    seq  = '{1'b0, 1'b0, 1'b1};
    hold = '{1'b1, 1'b0, 1'b0};
`endif
    for (int i = 0; i < seq.size(); i++) begin
      if (seq[i]) run_burst(1'b1, 1'b0, AW'(90), AW'(2), hold[i]);
      else        run_burst(1'b0, 1'b1, AW'(40), AW'(1), hold[i]);
    end
  endtask

  task automatic test_abort();
    bit bad;
    bit got;
    set_req(1'b0, 1'b1, 1'b1, AW'(20), AW'(5));
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (gnt0) got = 1'b1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL abort_gnt: gnt0=%b, want 1", gnt0); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, bram_ena, bram_wea, rd_vld, rd_ch} !== 8'b0 || bram_addra !== '0) begin
      failures++;
      $display("FAIL abort_now: ctrl=%b addr=%0d, want 0", {gnt0, gnt1, done0, done1, bram_ena, bram_wea, rd_vld, rd_ch}, bram_addra);
    end
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({gnt0, gnt1, done0, done1, bram_ena} !== 5'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL abort_after: activity after release, want none"); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++)
      run_burst(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom_range(0, 9)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_boundaries();
    test_random();
    test_tie();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1);
  end

  always @(negedge clk)
    if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL gnt_excl: gnt0=1 gnt1=1, want at most one");
    end
endmodule

// File: doc/fm_bram_1_arb.md
FM_BRAM_1_ARB -- requirements
Module: fm_bram_1_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the feature-map BRAM address width (128 words).
REQ-002 SHALL have parameter DATA_W, default 1024, meaning the feature-map BRAM word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic and the BRAM port.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have ports req0/req1, input, 1 bit: burst request from channel 0 or channel 1.
REQ-006 SHALL have ports req0_we/req1_we, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-007 SHALL have ports req0_addr/req1_addr, input, ADDR_W: burst start address.
REQ-008 SHALL have ports req0_len/req1_len, input, ADDR_W: number of beats minus 1.
REQ-009 SHALL have ports req0_din/req1_din, input, DATA_W: write data for the current beat.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 bit: channel owns the port; high for every beat cycle.
REQ-011 SHALL have ports done0/done1, output, 1 bit: one-cycle pulse after the channel's last beat is issued.
REQ-012 SHALL have port bram_ena, output, 1 bit: port-A enable.
REQ-013 SHALL have port bram_wea, output, 1 bit: port-A write enable.
REQ-014 SHALL have port bram_addra, output, ADDR_W: port-A address.
REQ-015 SHALL have port bram_dina, output, DATA_W: port-A write data.
REQ-016 SHALL have port rd_vld, output, 1 bit: bram_douta holds valid read data this cycle.
REQ-017 SHALL have port rd_ch, output, 1 bit: channel that owns the read data flagged by rd_vld.

Function
REQ-018 SHALL implement FSM states IDLE, BURST and DONE.
REQ-019 In IDLE, when any req is high, SHALL latch the winner's we, addr and len, and SHALL enter BURST on the next cycle.
REQ-020 In BURST, bram_ena SHALL be 1 and gnt of the winner SHALL be 1 every cycle.
- bram_wea = latched we.
- bram_addra = start + beat index, with wrap 127->0 (mod 2^ADDR_W).
- bram_dina = winner's reqN_din, passed combinationally.
REQ-021 The requester SHALL present beat k data in the k-th gnt cycle; this requires no backpressure.
REQ-022 After len+1 beats SHALL enter DONE, and doneN SHALL be 1 for exactly one cycle.
REQ-023 From DONE SHALL return to IDLE; minimum gap between bursts is 1 cycle.
REQ-024 rd_vld SHALL be bram_ena & ~bram_wea delayed 1 cycle; rd_ch SHALL be the channel delayed 1 cycle (BRAM read latency 1).
REQ-025 With len = 0 SHALL issue exactly one beat; len = 127 SHALL cover all 128 words.
REQ-026 A req deasserted mid-burst SHALL be ignored; the burst SHALL run to completion.
REQ-027 reqN_addr/len/we changes during BURST SHALL have no effect.
REQ-028 Simultaneous req0 and req1 in IDLE SHALL be resolved per REQ-033.
REQ-029 gnt0 and gnt1 SHALL never both be 1.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE and gnt0, gnt1, done0, done1, bram_ena, bram_wea, rd_vld, rd_ch, bram_addra, and the beat counter to 0.
REQ-031 Reset asserted mid-burst SHALL abort the burst with no done pulse; the remaining beats SHALL NOT be issued after release.
REQ-032 The round-robin pointer SHALL reset to favour channel 0.

Configuration
REQ-033 Macro FM_BRAM_1_ARB_RR_EN controls arbitration.
- Defined: round-robin; on a tie, the channel not granted last wins.
- Undefined: fixed priority; channel 0 always wins a tie.

Verification
REQ-034 Write test: req0 write, addr=10, len=3, din=beat index -> bram_wea=1 at addrs 10..13 for 4 cycles; done0 pulses 1 cycle after the last beat.
REQ-035 Read wrap test: req1 read, addr=126, len=3 -> addrs 126,127,0,1; rd_vld=1 with rd_ch=1 for 4 cycles, each lagging its address by 1.
REQ-036 Tie test: req0 and req1 both held high for two bursts each.
- With RR: order 0,1,0,1.
- Without RR: 0,0,... until req0 drops.
REQ-037 Abort test: rst_n low on beat 2 of a len=5 burst -> outputs 0 immediately; no done0; IDLE after release.
REQ-038 Stability test: req0 dropped and req0_addr changed mid-burst -> all len+1 beats still issued at the originally latched addresses.
